ce_tile_dispatcher: RTL and testbench

//  Queues TILE commands from the master control path and sequences them into the

---
 rtl/ce_tile_dispatcher.sv | 220 ++++++++++++++++++++++
 tb/tb_ce_tile_dispatcher.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ce_tile_dispatcher.sv
// ce_tile_dispatcher
//   Buffers TILE commands from the command decoder and feeds them to
//   compute_engine_modular one at a time. Each tile gets a single-cycle
//   o_tile_en pulse. The next tile is not started until i_tile_done arrives.
//   A tile is issued only when the downstream result FIFO has B*C free FP16
//   slots. This keeps the engine from ever stalling on almost-full.
//
//   Optional feature: define CE_DISPATCH_TIMEOUT_EN to add a BUSY watchdog.
//   The watchdog adds the sticky o_timeout port. When it fires, the tile is
//   abandoned and its credit is returned.
//
// Ports
//   i_clk, i_reset_n         clock, synchronous active-low reset
//   i_cmd_valid/o_cmd_ready  command handshake (ready = queue not full)
//   i_cmd_*                  command fields: addresses, B/C/V dims, flags
//                            {main_loop_over_left, right_man_4b, left_man_4b}
//   o_tile_en                1-cycle start pulse to the compute engine
//   o_left_addr..o_main_loop_over_left  tile parameters, held while in flight
//   i_tile_done              compute engine finished the current tile
//   i_result_pop             consumer removed one result FIFO entry
//   o_busy                   tile in progress or commands queued
//   o_cmd_err                1-cycle pulse: command dropped for bad dims
//   o_credit_used            result FIFO slots currently reserved
//   o_tiles_done             completed tile count (wraps)
//   o_timeout                (CE_DISPATCH_TIMEOUT_EN only) sticky watchdog flag
module ce_tile_dispatcher #(
  parameter int CMD_DEPTH      = 4,
  parameter int RES_FIFO_DEPTH = 512,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [15:0] i_cmd_left_addr,
  input  logic [15:0] i_cmd_right_addr,
  input  logic [7:0]  i_cmd_dim_b,
  input  logic [7:0]  i_cmd_dim_c,
  input  logic [7:0]  i_cmd_dim_v,
  input  logic [2:0]  i_cmd_flags,
  output logic        o_tile_en,
  output logic [15:0] o_left_addr,
  output logic [15:0] o_right_addr,
  output logic [7:0]  o_left_ugd_len,
  output logic [7:0]  o_right_ugd_len,
  output logic [7:0]  o_vec_len,
  output logic        o_left_man_4b,
  output logic        o_right_man_4b,
  output logic        o_main_loop_over_left,
  input  logic        i_tile_done,
  input  logic        i_result_pop,
  output logic        o_busy,
  output logic        o_cmd_err,
  output logic [15:0] o_credit_used,
`ifdef CE_DISPATCH_TIMEOUT_EN
  output logic        o_timeout,
`endif
  output logic [15:0] o_tiles_done
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 59;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);
  localparam logic [16:0]      DEPTH17  = 17'(RES_FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_BUSY} state_t;

  // Command queue
  logic [ENT_W-1:0] r_q_mem [CMD_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push, w_pop;
  logic [ENT_W-1:0] w_head;

  state_t      r_state;
  logic        r_tile_en, r_cmd_err;
  logic [15:0] r_left_addr, r_right_addr;
  logic [7:0]  r_dim_b, r_dim_c, r_dim_v;
  logic [2:0]  r_flags;
  logic [15:0] r_credit, r_tiles_done;

  logic [15:0] w_prod, w_sub, w_base, w_credit_nx;
  logic [16:0] w_room;
  logic        w_bad, w_fit, w_issue, w_timeout_hit;

  // Ready depends only on the stored count. A pop in the same cycle does
  // not open a slot until the next cycle.
  assign o_cmd_ready = (r_count != FULL_CNT);
  assign w_push      = i_cmd_valid && o_cmd_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_head      = r_q_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_mem[r_wr_ptr] <= {i_cmd_left_addr, i_cmd_right_addr, i_cmd_dim_b,
                            i_cmd_dim_c, i_cmd_dim_v, i_cmd_flags};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Credit check on the loaded command. Credit never exceeds the FIFO
  // depth, so the free-space calculation cannot wrap.
  assign w_prod  = {8'd0, r_dim_b} * {8'd0, r_dim_c};
  assign w_room  = DEPTH17 - {1'b0, r_credit};
  assign w_bad   = (r_dim_b == 8'd0) || (r_dim_c == 8'd0) || (r_dim_v == 8'd0) ||
                   ({1'b0, w_prod} > DEPTH17);
  assign w_fit   = ({1'b0, w_prod} <= w_room);
  assign w_issue = (r_state == S_CHECK) && !w_bad && w_fit;

`ifdef CE_DISPATCH_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic [15:0] r_prod;
  logic        r_timeout;
  assign w_timeout_hit = (r_state == S_BUSY) && !i_tile_done &&
                         (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign w_sub         = w_timeout_hit ? r_prod : 16'd0;
  assign o_timeout     = r_timeout;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_to_cnt  <= '0;
      r_prod    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_issue) begin
        r_to_cnt <= '0;
        r_prod   <= w_prod;
      end else if (r_state == S_BUSY) begin
        r_to_cnt <= r_to_cnt + 32'd1;
      end
      if (w_timeout_hit) r_timeout <= 1'b1;
    end
  end
`else
  assign w_timeout_hit = 1'b0;
  assign w_sub         = 16'd0;
`endif

  // Issue, timeout refund and pop can land in the same cycle.
  // A pop is ignored only when there is no credit left to return.
  assign w_base      = r_credit + (w_issue ? w_prod : 16'd0) - w_sub;
  assign w_credit_nx = (i_result_pop && (w_base != 16'd0)) ? (w_base - 16'd1) : w_base;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_tile_en    <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_left_addr  <= '0;
      r_right_addr <= '0;
      r_dim_b      <= '0;
      r_dim_c      <= '0;
      r_dim_v      <= '0;
      r_flags      <= '0;
      r_credit     <= '0;
      r_tiles_done <= '0;
    end else begin
      r_tile_en <= 1'b0;
      r_cmd_err <= 1'b0;
      r_credit  <= w_credit_nx;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_left_addr, r_right_addr, r_dim_b, r_dim_c, r_dim_v, r_flags} <= w_head;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_bad) begin
            r_cmd_err <= 1'b1;
            r_state   <= S_IDLE;
          end else if (w_fit) begin
            r_tile_en <= 1'b1;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (i_tile_done) begin
            r_tiles_done <= r_tiles_done + 16'd1;
            r_state      <= S_IDLE;
          end else if (w_timeout_hit) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tile_en             = r_tile_en;
  assign o_cmd_err             = r_cmd_err;
  assign o_left_addr           = r_left_addr;
  assign o_right_addr          = r_right_addr;
  assign o_left_ugd_len        = r_dim_b;
  assign o_right_ugd_len       = r_dim_c;
  assign o_vec_len             = r_dim_v;
  assign o_left_man_4b         = r_flags[0];
  assign o_right_man_4b        = r_flags[1];
  assign o_main_loop_over_left = r_flags[2];
  assign o_credit_used         = r_credit;
  assign o_tiles_done          = r_tiles_done;
  assign o_busy                = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_ce_tile_dispatcher.sv
module tb_ce_tile_dispatcher;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_left, cmd_right;
  logic [7:0]  cmd_b, cmd_c, cmd_v;
  logic [2:0]  cmd_flags;
  logic        tile_en;
  logic [15:0] left_addr, right_addr;
  logic [7:0]  left_len, right_len, vec_len;
  logic        left_4b, right_4b, main_left;
  logic        tile_done, result_pop;
  logic        busy, cmd_err;
  logic [15:0] credit_used, tiles_done;
`ifdef CE_DISPATCH_TIMEOUT_EN
  logic        timeout;
`endif

  always #5 clk = ~clk;

  ce_tile_dispatcher #(
    .CMD_DEPTH(4), .RES_FIFO_DEPTH(512), .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_left_addr(cmd_left), .i_cmd_right_addr(cmd_right),
    .i_cmd_dim_b(cmd_b), .i_cmd_dim_c(cmd_c), .i_cmd_dim_v(cmd_v),
    .i_cmd_flags(cmd_flags),
    .o_tile_en(tile_en),
    .o_left_addr(left_addr), .o_right_addr(right_addr),
    .o_left_ugd_len(left_len), .o_right_ugd_len(right_len), .o_vec_len(vec_len),
    .o_left_man_4b(left_4b), .o_right_man_4b(right_4b),
    .o_main_loop_over_left(main_left),
    .i_tile_done(tile_done), .i_result_pop(result_pop),
    .o_busy(busy), .o_cmd_err(cmd_err), .o_credit_used(credit_used),
`ifdef CE_DISPATCH_TIMEOUT_EN
    .o_timeout(timeout),
`endif
    .o_tiles_done(tiles_done)
  );

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [7:0]  v;
    logic [2:0]  f;
  } tile_t;

  tile_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int en_seen = 0;
  int err_seen = 0;

  // Scoreboard: every issued tile must match the oldest accepted good command.
  always @(negedge clk) begin
    if (reset_n && cmd_err) err_seen++;
    if (reset_n && tile_en) begin
      tile_t exp_t;
      tile_t got_t;
      en_seen++;
      n_tests++;
      got_t = '{left_addr, right_addr, left_len, right_len, vec_len,
                {main_left, right_4b, left_4b}};
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_tile: got %h, required none", got_t);
      end else begin
        exp_t = sb.pop_front();
        if (got_t !== exp_t) begin
          n_fail++;
          $display("FAIL sb_tile_fields: got %h, required %h", got_t, exp_t);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [15:0] l, input logic [15:0] r,
                          input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] v, input logic [2:0] f,
                          output bit acc);
    int prod;
    cmd_left = l; cmd_right = r; cmd_b = b; cmd_c = c; cmd_v = v; cmd_flags = f;
    cmd_valid = 1'b1;
    acc = cmd_ready;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    prod = int'(b) * int'(c);
    if (acc && b != 0 && c != 0 && v != 0 && prod <= 512)
      sb.push_back('{l, r, b, c, v, f});
  endtask

  task automatic pulse_done();
    tile_done = 1'b1;
    step(1);
    tile_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_left = 16'h1111; cmd_right = 16'h2222;
    cmd_b = 8'd2; cmd_c = 8'd2; cmd_v = 8'd2; cmd_flags = 3'b111;
    step(3);
    n_tests++;
    if ({tile_en, cmd_err, busy, credit_used, tiles_done, left_addr, right_addr,
         left_len, right_len, vec_len, left_4b, right_4b, main_left} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%b err=%b busy=%b credit=%0d tiles=%0d l=%h r=%h, required all 0",
               tile_en, cmd_err, busy, credit_used, tiles_done, left_addr, right_addr);
    end
    cmd_valid = 1'b0;
    reset_n = 1'b1;
    step(1);
    n_tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_single();
    bit acc;
    push_cmd(16'h0100, 16'h0200, 8'd4, 8'd4, 8'd2, 3'b001, acc);
    n_tests++;
    if (tile_en !== 1'b0) begin n_fail++; $display("FAIL single_en_n0: got %b, required 0", tile_en); end
    step(1);
    n_tests++;
    if (tile_en !== 1'b0) begin n_fail++; $display("FAIL single_en_n1: got %b, required 0", tile_en); end
    step(1);
    n_tests++;
    if (tile_en !== 1'b1 || credit_used !== 16'd16) begin
      n_fail++;
      $display("FAIL single_issue: en=%b credit=%0d, required 1 16", tile_en, credit_used);
    end
    step(1);
    n_tests++;
    if (tile_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_one_pulse: en=%b busy=%b, required 0 1", tile_en, busy);
    end
    pulse_done();
    n_tests++;
    if (tiles_done !== 16'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: tiles=%0d busy=%b, required 1 0", tiles_done, busy);
    end
    // 16 pops drain the credit, the extra ones must saturate at zero
    result_pop = 1'b1;
    step(18);
    result_pop = 1'b0;
    n_tests++;
    if (credit_used !== 16'd0) begin
      n_fail++;
      $display("FAIL single_credit_sat: got %0d, required 0", credit_used);
    end
  endtask

  task automatic test_credit_stall();
    bit acc;
    int en0;
    push_cmd(16'h0300, 16'h0400, 8'd20, 8'd25, 8'd1, 3'b010, acc);
    step(2);
    n_tests++;
    if (tile_en !== 1'b1 || credit_used !== 16'd500) begin
      n_fail++;
      $display("FAIL stall_big_issue: en=%b credit=%0d, required 1 500", tile_en, credit_used);
    end
    pulse_done();
    en0 = en_seen;
    push_cmd(16'h0500, 16'h0600, 8'd4, 8'd4, 8'd1, 3'b100, acc);
    step(6);
    n_tests++;
    if (en_seen != en0 || busy !== 1'b1 || credit_used !== 16'd500) begin
      n_fail++;
      $display("FAIL stall_hold: issues=%0d busy=%b credit=%0d, required %0d 1 500",
               en_seen, busy, credit_used, en0);
    end
    result_pop = 1'b1;
    step(4);
    n_tests++;
    if (tile_en !== 1'b0 || credit_used !== 16'd496) begin
      n_fail++;
      $display("FAIL stall_after_pops: en=%b credit=%0d, required 0 496", tile_en, credit_used);
    end
    // fifth pop lands on the issue edge: +16 -1
    step(1);
    result_pop = 1'b0;
    n_tests++;
    if (tile_en !== 1'b1 || credit_used !== 16'd511) begin
      n_fail++;
      $display("FAIL stall_issue_pop: en=%b credit=%0d, required 1 511", tile_en, credit_used);
    end
    pulse_done();
    n_tests++;
    if (tiles_done !== 16'd3) begin
      n_fail++;
      $display("FAIL stall_tiles: got %0d, required 3", tiles_done);
    end
    result_pop = 1'b1;
    step(512);
    result_pop = 1'b0;
    n_tests++;
    if (credit_used !== 16'd0) begin
      n_fail++;
      $display("FAIL stall_drain: got %0d, required 0", credit_used);
    end
  endtask

  task automatic test_errors();
    bit acc;
    int en0, err0;
    logic [7:0] bad_b [2] = '{8'd0, 8'd32};
    logic [7:0] bad_c [2] = '{8'd4, 8'd32};
    en0 = en_seen;
    for (int k = 0; k < 2; k++) begin
      err0 = err_seen;
      push_cmd(16'h0700, 16'h0800, bad_b[k], bad_c[k], 8'd3, 3'b000, acc);
      step(2);
      n_tests++;
      if (cmd_err !== 1'b1) begin
        n_fail++;
        $display("FAIL err_pulse_%0d: got %b, required 1", k, cmd_err);
      end
      step(1);
      n_tests++;
      if (cmd_err !== 1'b0 || err_seen != err0 + 1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL err_single_%0d: err=%b pulses=%0d busy=%b, required 0 %0d 0",
                 k, cmd_err, err_seen - err0, busy, 1);
      end
    end
    n_tests++;
    if (en_seen != en0 || credit_used !== 16'd0 || tiles_done !== 16'd3) begin
      n_fail++;
      $display("FAIL err_side_effects: issues=%0d credit=%0d tiles=%0d, required %0d 0 3",
               en_seen - en0, credit_used, tiles_done, 0);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    push_cmd(16'h1000, 16'h2000, 8'd2, 8'd2, 8'd1, 3'b001, acc);
    step(2);
    for (int k = 1; k <= 4; k++) begin
      push_cmd(16'h1000 + 16'(k), 16'h2000 + 16'(k), 8'd2, 8'd2, 8'(k + 1), 3'(k), acc);
      n_tests++;
      if (acc !== 1'b1) begin
        n_fail++;
        $display("FAIL full_accept_%0d: ready=%b, required 1", k, acc);
      end
    end
    n_tests++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got %b, required 0", cmd_ready);
    end
    push_cmd(16'hDEAD, 16'hBEEF, 8'd2, 8'd2, 8'd9, 3'b111, acc);
    n_tests++;
    if (acc !== 1'b0) begin
      n_fail++;
      $display("FAIL full_reject: accepted=%b, required 0", acc);
    end
    for (int k = 0; k < 5; k++) begin
      pulse_done();
      step(1);
      n_tests++;
      if (tile_en !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_early_%0d: got %b, required 0", k, tile_en);
      end
      if (k == 0) begin
        n_tests++;
        if (cmd_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL full_ready_free: got %b, required 1", cmd_ready);
        end
      end
      if (k < 4) begin
        step(1);
        n_tests++;
        if (tile_en !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_issue_%0d: got %b, required 1", k, tile_en);
        end
      end
    end
    step(1);
    n_tests++;
    if (busy !== 1'b0 || credit_used !== 16'd20 || tiles_done !== 16'd8) begin
      n_fail++;
      $display("FAIL b2b_final: busy=%b credit=%0d tiles=%0d, required 0 20 8",
               busy, credit_used, tiles_done);
    end
    pulse_done();
    n_tests++;
    if (tiles_done !== 16'd8) begin
      n_fail++;
      $display("FAIL idle_done_ignored: got %0d, required 8", tiles_done);
    end
  endtask

`ifdef CE_DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    bit acc;
    push_cmd(16'h3000, 16'h4000, 8'd2, 8'd2, 8'd1, 3'b000, acc);
    step(2);
    n_tests++;
    if (tile_en !== 1'b1 || credit_used !== 16'd24) begin
      n_fail++;
      $display("FAIL to_issue: en=%b credit=%0d, required 1 24", tile_en, credit_used);
    end
    step(99);
    n_tests++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL to_early: timeout=%b busy=%b, required 0 1", timeout, busy);
    end
    step(1);
    n_tests++;
    if (timeout !== 1'b1 || busy !== 1'b0 || credit_used !== 16'd20) begin
      n_fail++;
      $display("FAIL to_fire: timeout=%b busy=%b credit=%0d, required 1 0 20",
               timeout, busy, credit_used);
    end
    pulse_done();
    step(3);
    n_tests++;
    if (timeout !== 1'b1 || tiles_done !== 16'd8) begin
      n_fail++;
      $display("FAIL to_sticky: timeout=%b tiles=%0d, required 1 8", timeout, tiles_done);
    end
  endtask
`endif

  initial begin
    cmd_valid = 1'b0; tile_done = 1'b0; result_pop = 1'b0; reset_n = 1'b0;
    cmd_left = '0; cmd_right = '0; cmd_b = '0; cmd_c = '0; cmd_v = '0; cmd_flags = '0;
    test_reset();
    test_single();
    test_credit_stall();
    test_errors();
    test_back_to_back();
`ifdef CE_DISPATCH_TIMEOUT_EN
    test_timeout();
`endif
    step(2);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending tiles, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
